instr_fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the single-cycle datapath and supplies its `instrCode`. It owns the fetch PC and issues word reads to instruction memory over a request/grant/response handshake. Returned words go into a small prefetch FIFO, and the FIFO presents them to the datapath over valid/ready together with their PC. A redirect input (branch/jump target) flushes all in-flight and buffered fetches and restarts fetching at the new address.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 117 +++++++++++
 tb/tb_instr_fetch_unit.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side constants and the prefetch entry type.
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: registered storage, head presented straight from the array.
// flush empties it; a pop in the flush cycle is still seen by the consumer.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int           DEPTH     = 2,
  parameter fetch_entry_t RST_ENTRY = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RST_ENTRY;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues credited word reads to imem and
// buffers returned words with their PC; redirect flushes and restarts fetch.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_code,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int           CW        = $clog2(FIFO_DEPTH) + 1;
  localparam fetch_entry_t RST_ENTRY = fetch_entry_t'{pc: RESET_PC, instr: '0};

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            grant;
  logic            credit_ok;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;
  logic            unused_bits;

  // In-flight plus buffered words never exceed the FIFO depth, so every
  // returned beat is guaranteed a slot.
  assign credit_ok  = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
  assign imem_req   = !reset && !redirect_valid && credit_ok;
  assign imem_addr  = fetch_pc_q;
  assign grant      = imem_req && imem_gnt;

  assign push_entry = fetch_entry_t'{pc: rsp_pc_q, instr: imem_rdata};
  assign pop        = instr_valid && instr_ready;

  assign instr_valid = !fifo_empty;
  assign instr_code  = head_entry.instr;
  assign instr_pc    = head_entry.pc;

  assign unused_bits = ^{redirect_pc[1:0], fifo_full};

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    push          = 1'b0;
    if (redirect_valid) begin
      // No grant is possible here; whatever is still in flight gets dropped.
      fetch_pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
      rsp_pc_d      = {redirect_pc[XLEN-1:2], 2'b00};
      outstanding_d = outstanding_q - CW'(imem_rvalid);
      discard_d     = outstanding_q - CW'(imem_rvalid);
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
      end
      outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
      if (imem_rvalid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + XLEN'(INSTR_BYTES);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .RST_ENTRY (RST_ENTRY)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model, stream scoreboard,
// directed corner sequences, a redirect vector table and a random phase.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;
  localparam logic [31:0] KEY   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_code;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_code     (instr_code),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic void check_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endfunction

  // Memory: in-order responses, each at least one cycle after its grant.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t memq[$];
  int    cyc      = 0;
  int    gnt_mode = 1;  // 0 never, 1 always, 2 random
  int    lat_min  = 0;
  int    lat_max  = 0;

  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (!reset && memq.size() > 0 && memq[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memq[0].addr ^ KEY;
        void'(memq.pop_front());
      end
      case (gnt_mode)
        0:       imem_gnt = 1'b0;
        1:       imem_gnt = 1'b1;
        default: imem_gnt = ($urandom_range(0, 3) != 0);
      endcase
      @(negedge clk);
      if (reset) begin
        memq.delete();
        imem_rvalid = 1'b0;
      end else if (imem_req && imem_gnt) begin
        mreq_t r;
        int    d;
        d = cyc + 1 + int'($urandom_range(lat_max, lat_min));
        if (memq.size() > 0 && d < memq[memq.size()-1].due) d = memq[memq.size()-1].due;
        r.addr = imem_addr;
        r.due  = d;
        memq.push_back(r);
      end
    end
  end

  // Scoreboard: consumed instructions form consecutive PCs from the last
  // reset/redirect target, and each carries the word stored at its PC.
  logic [31:0] exp_pc;
  int          consumed = 0;
  logic        p_req   = 1'b0;
  logic        p_gnt   = 1'b0;
  logic        p_redir = 1'b0;
  logic [31:0] p_addr  = '0;

  initial begin
    exp_pc = RPC;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_pc  = RPC;
        p_req   = 1'b0;
        p_gnt   = 1'b0;
        p_redir = 1'b0;
      end else begin
        if (p_req && !p_gnt && !p_redir && !redirect_valid) begin
          check_b("req_hold", imem_req, 1'b1);
          check("addr_hold", imem_addr, p_addr);
        end
        if (redirect_valid) check_b("req_in_redirect", imem_req, 1'b0);
        if (instr_valid && instr_ready) begin
          check("sb_pc", instr_pc, exp_pc);
          check("sb_code", instr_code, exp_pc ^ KEY);
          exp_pc = exp_pc + 32'd4;
          consumed++;
        end
        if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
        p_req   = imem_req;
        p_gnt   = imem_gnt;
        p_redir = redirect_valid;
        p_addr  = imem_addr;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1, "watchdog");
  end

  task automatic drive_pt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    drive_pt();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    drive_pt();
    drive_pt();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [31:0] pc_a;
    logic [31:0] pc_b;
    bit          two;
    logic [31:0] exp_addr;
  } rvec_t;

  rvec_t vecs[6];

  initial begin
    bit ok;
    bit found;
    int g;
    int k;
    int c0;

    vecs[0] = '{pc_a: 32'h0000_0203, pc_b: 32'h0,          two: 1'b0, exp_addr: 32'h0000_0200};
    vecs[1] = '{pc_a: 32'hFFFF_FFFF, pc_b: 32'h0,          two: 1'b0, exp_addr: 32'hFFFF_FFFC};
    vecs[2] = '{pc_a: 32'h0000_0101, pc_b: 32'h0,          two: 1'b0, exp_addr: 32'h0000_0100};
    vecs[3] = '{pc_a: 32'h1234_5678, pc_b: 32'h0,          two: 1'b0, exp_addr: 32'h1234_5678};
    vecs[4] = '{pc_a: 32'h0000_4000, pc_b: 32'h8000_0006,  two: 1'b1, exp_addr: 32'h8000_0004};
    vecs[5] = '{pc_a: 32'hDEAD_BEEF, pc_b: 32'h0000_0001,  two: 1'b1, exp_addr: 32'h0000_0000};

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b1;
    gnt_mode       = 1;
    lat_min        = 0;
    lat_max        = 0;

    // Reset values and first request
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_b("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, RPC);
    check_b("rst_valid", instr_valid, 1'b0);
    check("rst_code", instr_code, 32'h0);
    check("rst_pc", instr_pc, RPC);
    drive_pt();
    reset = 1'b0;
    @(negedge clk);
    check_b("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, RPC);

    // Stream after reset
    k = 0;
    for (int c = 0; c < 60 && k < 8; c++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        check("stream_pc", instr_pc, 32'(k * 4));
        check("stream_code", instr_code, 32'(k * 4) ^ KEY);
        k++;
      end
    end
    check("stream_count", k, 8);

    // Backpressure
    instr_ready = 1'b0;
    do_reset();
    g = 0;
    repeat (10) begin
      @(negedge clk);
      if (imem_req && imem_gnt) g++;
    end
    check("bp_grants", g, 2);
    check_b("bp_req_low", imem_req, 1'b0);
    drive_pt();
    instr_ready = 1'b1;
    @(negedge clk);
    check_b("bp_valid0", instr_valid, 1'b1);
    check("bp_pc0", instr_pc, 32'h0);
    @(negedge clk);
    check_b("bp_valid1", instr_valid, 1'b1);
    check("bp_pc1", instr_pc, 32'h4);

    // Redirect with two requests in flight
    lat_min = 5;
    lat_max = 5;
    do_reset();
    g = 0;
    repeat (2) begin
      @(negedge clk);
      if (imem_req && imem_gnt) g++;
    end
    check("rd2_inflight", g, 2);
    drive_pt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    @(negedge clk);
    check_b("rd2_req_off", imem_req, 1'b0);
    drive_pt();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rd2_addr", imem_addr, 32'h0000_0100);
    check_b("rd2_valid_low", instr_valid, 1'b0);
    wait_valid(40, ok);
    check_b("rd2_timeout", ok, 1'b1);
    check("rd2_first_pc", instr_pc, 32'h0000_0100);
    check("rd2_first_code", instr_code, 32'h0000_0100 ^ KEY);

    // Redirect coinciding with a response beat, misaligned target
    lat_min = 0;
    lat_max = 0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_pt();
      if (imem_rvalid) begin
        found = 1'b1;
        break;
      end
    end
    check_b("rv_found", found, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    @(negedge clk);
    check_b("rv_req_off", imem_req, 1'b0);
    drive_pt();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rv_addr", imem_addr, 32'h0000_0200);
    wait_valid(20, ok);
    check_b("rv_timeout", ok, 1'b1);
    check("rv_first_pc", instr_pc, 32'h0000_0200);

    // Push and pop in the same cycle
    instr_ready = 1'b0;
    lat_min     = 2;
    lat_max     = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_pt();
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    check_b("pp_found", found, 1'b1);
    check_b("pp_rvalid", imem_rvalid, 1'b1);
    instr_ready = 1'b1;
    @(negedge clk);
    check_b("pp_valid0", instr_valid, 1'b1);
    check("pp_pc0", instr_pc, 32'h0);
    @(negedge clk);
    check_b("pp_valid1", instr_valid, 1'b1);
    check("pp_pc1", instr_pc, 32'h4);

    // Reset mid-stream, then redirect to the top of the address space
    instr_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive_pt();
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    check_b("mr_found", found, 1'b1);
    reset    = 1'b1;
    gnt_mode = 0;
    @(negedge clk);
    check_b("mr_valid", instr_valid, 1'b0);
    check("mr_addr", imem_addr, RPC);
    check_b("mr_req", imem_req, 1'b0);
    check("mr_code", instr_code, 32'h0);
    check("mr_pc", instr_pc, RPC);
    drive_pt();
    reset       = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    check_b("mr_req_after", imem_req, 1'b1);
    check("mr_addr_after", imem_addr, RPC);
    drive_pt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    @(negedge clk);
    drive_pt();
    redirect_valid = 1'b0;
    gnt_mode       = 1;
    @(negedge clk);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check_b("wrap_req", imem_req, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("wrap_next", imem_addr, 32'h0000_0000);
    wait_valid(20, ok);
    check_b("wrap_timeout", ok, 1'b1);
    check("wrap_first_pc", instr_pc, 32'hFFFF_FFFC);

    // Redirect vector table: alignment and back-to-back redirects
    gnt_mode = 0;
    lat_min  = 0;
    lat_max  = 0;
    do_reset();
    foreach (vecs[i]) begin
      drive_pt();
      redirect_valid = 1'b1;
      redirect_pc    = vecs[i].pc_a;
      if (vecs[i].two) begin
        drive_pt();
        redirect_pc = vecs[i].pc_b;
      end
      @(negedge clk);
      check_b("tbl_req_off", imem_req, 1'b0);
      drive_pt();
      redirect_valid = 1'b0;
      @(negedge clk);
      check("tbl_addr", imem_addr, vecs[i].exp_addr);
      check_b("tbl_req", imem_req, 1'b1);
      check_b("tbl_valid", instr_valid, 1'b0);
    end

    // Random traffic against the scoreboard
    gnt_mode = 2;
    lat_min  = 0;
    lat_max  = 3;
    do_reset();
    c0 = consumed;
    for (int i = 0; i < 1500; i++) begin
      drive_pt();
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom();
    end
    drive_pt();
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    gnt_mode       = 1;
    repeat (30) @(negedge clk);
    check_b("rand_progress", (consumed - c0) > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
